frame_buffer: RTL and testbench
===============================

Name: frame_buffer

Overview:
- Pixel sink at the far end of the sprite command path: accepts single-pixel writes (fb_wfb) and draw/present requests (fb_dfb), and reports fb_busy back to the command controller.
- Double-buffered: writes land in the back bank; the display scan-out reads the front bank.
- On fb_dfb the block waits for the next vertical-blank rising edge, flips banks, then copies the new front bank into the new back bank. Incremental drawing therefore continues from the presented frame.

Parameters:
- X_BITS, 8, x coordinate width
- Y_BITS, 8, y coordinate width
- C_W, 8, width of each colour channel
- PIXELS, 2**(X_BITS+Y_BITS), pixels per bank (derived; do not override)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- fb_wfb  in  1  write pixel to back bank
- fb_dfb  in  1  present request
- fb_px  in  X_BITS+Y_BITS  pixel address {x,y}
- fb_r, fb_g, fb_b  in  C_W each  write colour
- fb_busy  out  1  present/copy in progress
- wr_drop  out  1  sticky: a write or present was ignored while busy
- disp_rd  in  1  display read strobe
- disp_px  in  X_BITS+Y_BITS  display read address {x,y}
- disp_vblank  in  1  vertical blank level from the display timing block
- disp_r, disp_g, disp_b  out  C_W each  front-bank read data
- disp_valid  out  1  disp_* data valid

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.
- Storage:
  - Two banks of PIXELS words, each word {r,g,b} (3*C_W bits).
  - Each bank has one write port and two read ports; all reads are registered (1-cycle latency).
  - Address = fb_px / disp_px used directly (x in the upper bits).
  - Memory contents are not cleared by reset.
- front_sel register: front bank = bank[front_sel]; back bank = bank[~front_sel].
- Reset values:
  - state IDLE, front_sel 0, copy counter 0
  - fb_busy 0, wr_drop 0, disp_valid 0, disp_r/g/b 0
  - vblank edge register 0
- Display port:
  - disp_rd sampled in cycle n gives disp_valid=1 and front[disp_px] on disp_* in cycle n+1.
  - disp_valid=0 otherwise; disp_* hold their last value.
  - Reads are always from the current front bank, independent of state.
  - A read issued in the flip cycle returns data from the pre-flip front bank.
- vblank edge:
  - vb_q <= disp_vblank each cycle.
  - vb_rise = disp_vblank & ~vb_q.
- States:
  - IDLE:
    - fb_wfb: back[fb_px] <= {fb_r,fb_g,fb_b}.
    - fb_dfb: go to WAIT_VB; fb_busy=1 from the next cycle.
    - Both fb_wfb and fb_dfb asserted: the write is performed and the present is accepted.
  - WAIT_VB:
    - On vb_rise: front_sel toggles, counter <= 0, go to COPY.
    - A vblank that was already high on entry does not count; wait for the next rising edge.
  - COPY:
    - Each cycle, read front[counter] and write back[counter-1] with the data read in the previous cycle (no write in the first COPY cycle).
    - counter increments and wraps naturally.
    - After the read of PIXELS-1, go to DRAIN.
  - DRAIN:
    - Write back[PIXELS-1], go to IDLE.
    - fb_busy=0 from the following cycle.
- fb_busy:
  - Registered; 1 exactly while state != IDLE.
  - Busy duration after fb_dfb = (cycles to vb_rise) + PIXELS + 1.
- While busy:
  - fb_wfb and fb_dfb are ignored (no memory write, no second present) and set wr_drop=1.
  - wr_drop clears only on rst.
- rst mid-operation:
  - Aborts WAIT_VB/COPY immediately and restores all reset values, including front_sel=0.
  - A partial copy is left as-is in memory.
- Widths: counter is X_BITS+Y_BITS+1 bits so termination at PIXELS is detectable; no saturation anywhere.

Test Plan (X_BITS=2, Y_BITS=2, PIXELS=16, C_W=8):
1. Write path: rst; fb_wfb px=5 rgb=0x112233; fb_dfb; pulse vblank -> fb_busy high for 18 cycles after vb_rise. disp_rd px=5 then returns 0x112233 with disp_valid one cycle later.
2. Copy-forward: after scenario 1, fb_wfb px=6 rgb=0xAABBCC; present again -> display px=5 = 0x112233 and px=6 = 0xAABBCC. All 16 back-bank words equal the front bank after the copy.
3. Vblank gating: hold disp_vblank=1, then assert fb_dfb -> no flip and fb_busy stays 1 until vblank falls and rises again. A display read during the wait returns old front data.
4. Busy drops: during COPY, fb_wfb px=3 rgb=0xFFFFFF -> back[3] not written and wr_drop=1. A second fb_dfb in WAIT_VB produces no extra flip.
5. Reset mid-copy: rst asserted in COPY cycle 7 -> next cycle fb_busy=0, wr_drop=0, disp_valid=0, front_sel=0.
6. Simultaneous: fb_wfb+fb_dfb in the same IDLE cycle -> pixel written, busy 1 next cycle, and the pixel is visible after the flip.

Source files
------------

// File: rtl/frame_buffer_if.sv
// Command and display bus of the double-buffered frame buffer.
// The master side is the sprite command controller plus the display timing/scan-out.
// The slave side is the frame buffer itself.
interface frame_buffer_if #(
    parameter int X_BITS = 8,
    parameter int Y_BITS = 8,
    parameter int C_W    = 8
);
    localparam int A_W = X_BITS + Y_BITS;

    // command path
    logic           fb_wfb;
    logic           fb_dfb;
    logic [A_W-1:0] fb_px;
    logic [C_W-1:0] fb_r;
    logic [C_W-1:0] fb_g;
    logic [C_W-1:0] fb_b;
    logic           fb_busy;
    logic           wr_drop;

    // display path
    logic           disp_rd;
    logic [A_W-1:0] disp_px;
    logic           disp_vblank;
    logic [C_W-1:0] disp_r;
    logic [C_W-1:0] disp_g;
    logic [C_W-1:0] disp_b;
    logic           disp_valid;

    modport master (
        output fb_wfb, fb_dfb, fb_px, fb_r, fb_g, fb_b,
        output disp_rd, disp_px, disp_vblank,
        input  fb_busy, wr_drop,
        input  disp_r, disp_g, disp_b, disp_valid
    );

    modport slave (
        input  fb_wfb, fb_dfb, fb_px, fb_r, fb_g, fb_b,
        input  disp_rd, disp_px, disp_vblank,
        output fb_busy, wr_drop,
        output disp_r, disp_g, disp_b, disp_valid
    );
endinterface

// File: rtl/frame_buffer.sv
// Double-buffered frame buffer.
// Pixel writes land in the back bank, and the display reads the front bank.
// A present request waits for the next vblank rising edge and then flips the banks.
// After the flip, the new front bank is copied into the new back bank, so incremental
// drawing continues from the frame that was just presented.
module frame_buffer #(
    parameter int X_BITS = 8,
    parameter int Y_BITS = 8,
    parameter int C_W    = 8
) (
    input  logic         clk,
    input  logic         rst,
    frame_buffer_if.slave bus
);
    localparam int A_W    = X_BITS + Y_BITS;
    localparam int PIXELS = 2 ** A_W;
    localparam int W_W    = 3 * C_W;

    typedef enum logic [1:0] {IDLE, WAIT_VB, COPY, DRAIN} state_t;

    // Two banks, each word {r,g,b}; contents survive reset
    logic [W_W-1:0] mem0 [PIXELS];
    logic [W_W-1:0] mem1 [PIXELS];

    state_t         state;
    state_t         state_nxt;
    logic           front_sel;
    logic           front_nxt;
    logic [A_W:0]   cnt;
    logic [A_W:0]   cnt_nxt;
    logic [A_W:0]   cnt_inc;
    logic [A_W-1:0] cnt_m1;
    logic           vb_q;
    logic           vb_rise;
    logic           busy_q;
    logic           drop_q;
    logic           drop_nxt;

    logic           wr_en;
    logic [A_W-1:0] wr_addr;
    logic [W_W-1:0] wr_data;

    logic [W_W-1:0] copy_rd_p1;
    logic [W_W-1:0] disp_word_p1;
    logic           vld_p1;

    assign vb_rise = bus.disp_vblank & ~vb_q;
    assign cnt_inc = cnt + (A_W+1)'(1);
    // In DRAIN the counter sits at PIXELS, so the low bits minus one wrap to PIXELS-1
    assign cnt_m1  = cnt[A_W-1:0] - A_W'(1);

    // Next-state, bank-write selection and drop detection
    always_comb begin
        state_nxt = state;
        front_nxt = front_sel;
        cnt_nxt   = cnt;
        drop_nxt  = drop_q;
        wr_en     = 1'b0;
        wr_addr   = bus.fb_px;
        wr_data   = {bus.fb_r, bus.fb_g, bus.fb_b};
        case (state)
            IDLE: begin
                wr_en = bus.fb_wfb;
                if (bus.fb_dfb) begin
                    state_nxt = WAIT_VB;
                end
            end
            WAIT_VB: begin
                if (vb_rise) begin
                    front_nxt = ~front_sel;
                    cnt_nxt   = '0;
                    state_nxt = COPY;
                end
            end
            COPY: begin
                cnt_nxt = cnt_inc;
                wr_en   = (cnt != '0);
                wr_addr = cnt_m1;
                wr_data = copy_rd_p1;
                if (cnt_inc[A_W]) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                wr_en     = 1'b1;
                wr_addr   = cnt_m1;
                wr_data   = copy_rd_p1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE && (bus.fb_wfb || bus.fb_dfb)) begin
            drop_nxt = 1'b1;
        end
    end

    // Control registers: state, bank select, copy counter, vblank edge, status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            front_sel <= 1'b0;
            cnt       <= '0;
            vb_q      <= 1'b0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            front_sel <= front_nxt;
            cnt       <= cnt_nxt;
            vb_q      <= bus.disp_vblank;
            busy_q    <= (state_nxt != IDLE);
            drop_q    <= drop_nxt;
        end
    end

    // Single write port per bank; only the back bank (bank[~front_sel]) is ever written
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            if (front_sel) begin
                mem0[wr_addr] <= wr_data;
            end else begin
                mem1[wr_addr] <= wr_data;
            end
        end
    end

    // p0 -> p1: copy read of the front bank, consumed by the back-bank write one cycle later
    always_ff @(posedge clk) begin
        copy_rd_p1 <= front_sel ? mem1[cnt[A_W-1:0]] : mem0[cnt[A_W-1:0]];
    end

    // p0 -> p1: display read of the front bank; data holds while no read is issued
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            disp_word_p1 <= '0;
        end else begin
            vld_p1 <= bus.disp_rd;
            if (bus.disp_rd) begin
                disp_word_p1 <= front_sel ? mem1[bus.disp_px] : mem0[bus.disp_px];
            end
        end
    end

    assign bus.fb_busy    = busy_q;
    assign bus.wr_drop    = drop_q;
    assign bus.disp_valid = vld_p1;
    assign bus.disp_r     = disp_word_p1[3*C_W-1:2*C_W];
    assign bus.disp_g     = disp_word_p1[2*C_W-1:C_W];
    assign bus.disp_b     = disp_word_p1[C_W-1:0];
endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer with a 4x4 bank (16 pixels).
// It covers the write path, copy-forward, vblank gating, busy drops,
// reset in the middle of a copy, and a write and present in the same cycle.
module tb_frame_buffer;
    localparam int XB = 2;
    localparam int YB = 2;
    localparam int CW = 8;
    localparam int NPX = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_bad = 0;
    int   n;

    logic [23:0] bk  [NPX];
    logic [23:0] img [NPX];
    logic [23:0] disp_word;

    frame_buffer_if #(.X_BITS(XB), .Y_BITS(YB), .C_W(CW)) bus ();

    frame_buffer #(.X_BITS(XB), .Y_BITS(YB), .C_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign disp_word = {bus.disp_r, bus.disp_g, bus.disp_b};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] pv(input int i);
        return {8'(i), 8'(8'hA0 + i), 8'(8'h50 - i)};
    endfunction

    task automatic wr(input int px, input logic [23:0] v);
        bus.fb_wfb = 1'b1;
        bus.fb_px  = 4'(px);
        {bus.fb_r, bus.fb_g, bus.fb_b} = v;
        tick();
        bus.fb_wfb = 1'b0;
        bk[px] = v;
    endtask

    task automatic rd(input string tag, input int px, input logic [23:0] exp);
        bus.disp_rd = 1'b1;
        bus.disp_px = 4'(px);
        tick();
        bus.disp_rd = 1'b0;
        chk({tag, "_v"}, 32'(bus.disp_valid), 32'd1);
        chk(tag, 32'(disp_word), 32'(exp));
    endtask

    // Pulse vblank for one cycle and count the cycles for which busy is seen high
    task automatic vb_done(output int cnt);
        bus.disp_vblank = 1'b1;
        cnt = 0;
        while (bus.fb_busy && cnt < 200) begin
            cnt++;
            tick();
            bus.disp_vblank = 1'b0;
        end
        bus.disp_vblank = 1'b0;
    endtask

    task automatic present(output int cnt);
        bus.fb_dfb = 1'b1;
        tick();
        bus.fb_dfb = 1'b0;
        tick();
        vb_done(cnt);
        img = bk;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.fb_wfb = 1'b0; bus.fb_dfb = 1'b0; bus.fb_px = '0;
        bus.fb_r = '0; bus.fb_g = '0; bus.fb_b = '0;
        bus.disp_rd = 1'b0; bus.disp_px = '0; bus.disp_vblank = 1'b0;
        for (int i = 0; i < NPX; i++) begin
            bk[i] = '0;
            img[i] = '0;
        end
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy",  32'(bus.fb_busy), 32'd0);
        chk("rst_drop",  32'(bus.wr_drop), 32'd0);
        chk("rst_valid", 32'(bus.disp_valid), 32'd0);
        chk("rst_data",  32'(disp_word), 32'd0);
        chk("rst_front", 32'(dut.front_sel), 32'd0);

        // 1: write path (fill the back bank so both banks become fully known)
        for (int i = 0; i < NPX; i++) wr(i, pv(i));
        wr(5, 24'h112233);
        present(n);
        chk("t1_busy_len", 32'(n), 32'd18);
        chk("t1_front", 32'(dut.front_sel), 32'd1);
        rd("t1_px5", 5, 24'h112233);
        tick();
        chk("t1_valid_low", 32'(bus.disp_valid), 32'd0);
        chk("t1_hold", 32'(disp_word), 32'h112233);

        // 2: copy-forward
        wr(6, 24'hAABBCC);
        present(n);
        chk("t2_busy_len", 32'(n), 32'd18);
        rd("t2_px5", 5, 24'h112233);
        rd("t2_px6", 6, 24'hAABBCC);
        present(n);
        chk("t2_front", 32'(dut.front_sel), 32'd1);
        for (int i = 0; i < NPX; i++) rd($sformatf("t2_copy%0d", i), i, img[i]);

        // 3: vblank gating, plus a read in the flip cycle
        wr(7, 24'h777777);
        bus.disp_vblank = 1'b1;
        tick();
        tick();
        bus.fb_dfb = 1'b1;
        tick();
        bus.fb_dfb = 1'b0;
        repeat (4) tick();
        chk("t3_busy_hold", 32'(bus.fb_busy), 32'd1);
        chk("t3_no_flip", 32'(dut.front_sel), 32'd1);
        rd("t3_wait_rd", 7, img[7]);
        bus.disp_vblank = 1'b0;
        tick();
        chk("t3_busy_low_vb", 32'(bus.fb_busy), 32'd1);
        bus.disp_vblank = 1'b1;
        bus.disp_rd = 1'b1;
        bus.disp_px = 4'd7;
        tick();
        bus.disp_rd = 1'b0;
        bus.disp_vblank = 1'b0;
        chk("t3_flip_rd", 32'(disp_word), 32'(img[7]));
        chk("t3_flipped", 32'(dut.front_sel), 32'd0);
        img = bk;
        n = 0;
        while (bus.fb_busy && n < 200) begin
            n++;
            tick();
        end
        chk("t3_rest_len", 32'(n), 32'd17);
        rd("t3_px7", 7, 24'h777777);

        // 4: drops while busy
        bus.fb_dfb = 1'b1;
        tick();
        tick();
        bus.fb_dfb = 1'b0;
        chk("t4_drop_dfb", 32'(bus.wr_drop), 32'd1);
        bus.disp_vblank = 1'b1;
        tick();
        bus.disp_vblank = 1'b0;
        img = bk;
        repeat (9) tick();
        bus.fb_wfb = 1'b1;
        bus.fb_px = 4'd3;
        {bus.fb_r, bus.fb_g, bus.fb_b} = 24'hFFFFFF;
        tick();
        bus.fb_wfb = 1'b0;
        n = 0;
        while (bus.fb_busy && n < 200) begin
            n++;
            tick();
        end
        repeat (3) tick();
        chk("t4_no_requeue", 32'(bus.fb_busy), 32'd0);
        chk("t4_one_flip", 32'(dut.front_sel), 32'd1);
        chk("t4_sticky", 32'(bus.wr_drop), 32'd1);
        present(n);
        chk("t4_busy_len", 32'(n), 32'd18);
        rd("t4_px3", 3, pv(3));

        // 5: reset in COPY cycle 7
        bus.fb_dfb = 1'b1;
        tick();
        bus.fb_dfb = 1'b0;
        bus.disp_vblank = 1'b1;
        tick();
        bus.disp_vblank = 1'b0;
        repeat (7) tick();
        chk("t5_pre_busy", 32'(bus.fb_busy), 32'd1);
        rst = 1'b1;
        bus.disp_rd = 1'b1;
        bus.disp_px = 4'd0;
        tick();
        rst = 1'b0;
        bus.disp_rd = 1'b0;
        chk("t5_busy", 32'(bus.fb_busy), 32'd0);
        chk("t5_drop", 32'(bus.wr_drop), 32'd0);
        chk("t5_valid", 32'(bus.disp_valid), 32'd0);
        chk("t5_front", 32'(dut.front_sel), 32'd0);
        chk("t5_data", 32'(disp_word), 32'd0);
        tick();
        chk("t5_idle", 32'(bus.fb_busy), 32'd0);

        // 6: write and present in the same IDLE cycle
        bus.fb_wfb = 1'b1;
        bus.fb_dfb = 1'b1;
        bus.fb_px = 4'd9;
        {bus.fb_r, bus.fb_g, bus.fb_b} = 24'h123456;
        tick();
        bus.fb_wfb = 1'b0;
        bus.fb_dfb = 1'b0;
        chk("t6_busy", 32'(bus.fb_busy), 32'd1);
        chk("t6_no_drop", 32'(bus.wr_drop), 32'd0);
        tick();
        vb_done(n);
        chk("t6_busy_len", 32'(n), 32'd18);
        rd("t6_px9", 9, 24'h123456);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
